// File: rtl/gpio_in_debounce.sv
// Board switch/button input conditioner: per-channel synchronizer, confirm-counter
// debounce FSM and registered rise/fall event pulses.
module gpio_in_debounce #(
    parameter int unsigned Width          = 4,
    parameter int unsigned DebounceCycles = 20000,
    parameter int unsigned SyncStages     = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             bypass_i,
    input  logic [Width-1:0] sw_i,
    output logic [Width-1:0] sw_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic             changed_o
);

    localparam int unsigned CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    typedef enum logic [1:0] {
        StLow   = 2'd0,
        StConfH = 2'd1,
        StHigh  = 2'd2,
        StConfL = 2'd3
    } state_e;

    (* ASYNC_REG = "TRUE" *) logic [Width-1:0] sync_q [SyncStages];
    logic [Width-1:0] sync;

    state_e           state_q [Width];
    state_e           state_d [Width];
    logic [CntW-1:0]  cnt_q   [Width];
    logic [CntW-1:0]  cnt_d   [Width];

    logic [Width-1:0] sw_q, sw_d;
    logic [Width-1:0] rise_q, rise_d;
    logic [Width-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;

    // Plain flop chain; the only path from the raw pins into the design.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(SyncStages); i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sw_i;
            for (int i = 1; i < int'(SyncStages); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync = sync_q[SyncStages-1];

    // Per-channel debounce next state; bypass pins the FSM to the idle state
    // matching sync so leaving bypass cannot produce an event.
    always_comb begin
        sw_d = sw_q;
        for (int n = 0; n < int'(Width); n++) begin
            state_d[n] = state_q[n];
            cnt_d[n]   = cnt_q[n];
            if (bypass_i) begin
                sw_d[n]    = sync[n];
                state_d[n] = sync[n] ? StHigh : StLow;
                cnt_d[n]   = '0;
            end else begin
                unique case (state_q[n])
                    StLow: begin
                        if (sync[n]) begin
                            state_d[n] = StConfH;
                            cnt_d[n]   = '0;
                        end
                    end
                    StConfH: begin
                        if (!sync[n]) begin
                            state_d[n] = StLow;
                            cnt_d[n]   = '0;
                        end else if (cnt_q[n] == CntLast) begin
                            state_d[n] = StHigh;
                            cnt_d[n]   = '0;
                            sw_d[n]    = 1'b1;
                        end else begin
                            cnt_d[n] = cnt_q[n] + CntW'(1);
                        end
                    end
                    StHigh: begin
                        if (!sync[n]) begin
                            state_d[n] = StConfL;
                            cnt_d[n]   = '0;
                        end
                    end
                    StConfL: begin
                        if (sync[n]) begin
                            state_d[n] = StHigh;
                            cnt_d[n]   = '0;
                        end else if (cnt_q[n] == CntLast) begin
                            state_d[n] = StLow;
                            cnt_d[n]   = '0;
                            sw_d[n]    = 1'b0;
                        end else begin
                            cnt_d[n] = cnt_q[n] + CntW'(1);
                        end
                    end
                    default: begin
                        state_d[n] = StLow;
                        cnt_d[n]   = '0;
                    end
                endcase
            end
        end
    end

    // Events derive from the level change so they line up with sw_o.
    always_comb begin
        rise_d    = sw_d & ~sw_q;
        fall_d    = ~sw_d & sw_q;
        changed_d = |(rise_d | fall_d);
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int n = 0; n < int'(Width); n++) begin
                state_q[n] <= StLow;
                cnt_q[n]   <= '0;
            end
            sw_q      <= '0;
            rise_q    <= '0;
            fall_q    <= '0;
            changed_q <= 1'b0;
        end else begin
            for (int n = 0; n < int'(Width); n++) begin
                state_q[n] <= state_d[n];
                cnt_q[n]   <= cnt_d[n];
            end
            sw_q      <= sw_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    assign sw_o      = sw_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign changed_o = changed_q;

endmodule

// File: tb/tb_gpio_in_debounce.sv
// Directed bench for gpio_in_debounce with Width=4, DebounceCycles=4, SyncStages=2.
module tb_gpio_in_debounce;

    logic       clk;
    logic       rst_n;
    logic       bypass;
    logic [3:0] sw_in;
    logic [3:0] sw_out;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       changed;

    int checks = 0;
    int errors = 0;
    int acc;

    gpio_in_debounce #(
        .Width          (4),
        .DebounceCycles (4),
        .SyncStages     (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .bypass_i  (bypass),
        .sw_i      (sw_in),
        .sw_o      (sw_out),
        .rise_o    (rise),
        .fall_o    (fall),
        .changed_o (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past one rising edge; outputs are sampled 1 time unit later.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        bypass = 1'b0;
        sw_in  = 4'hF;

        // Reset held for three edges with all pins high.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_sw", 32'(sw_out), 32'h0);
            check("rst_ev", 32'({rise, fall, changed}), 32'h0);
        end

        // Release: first sampling edge is the next one; update 6 edges later.
        rst_n = 1'b1;
        tick(6);
        check("rel_sw_early", 32'(sw_out), 32'h0);
        check("rel_rise_early", 32'(rise), 32'h0);
        tick(1);
        check("rel_sw", 32'(sw_out), 32'hF);
        check("rel_rise", 32'(rise), 32'hF);
        check("rel_changed", 32'(changed), 32'h1);
        tick(1);
        check("rel_rise_once", 32'(rise), 32'h0);
        check("rel_changed_once", 32'(changed), 32'h0);

        // Back to all-low.
        sw_in = 4'h0;
        tick(7);
        check("all_fall", 32'(fall), 32'hF);
        check("all_low", 32'(sw_out), 32'h0);
        tick(2);

        // Glitch: three cycles high on channel 0 is rejected.
        acc = 0;
        sw_in = 4'h1;
        tick(3);
        sw_in = 4'h0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (rise[0] || changed) acc++;
        end
        check("glitch_no_rise", 32'(acc), 32'h0);
        check("glitch_sw", 32'(sw_out), 32'h0);

        // Stable high on channel 0 is accepted after the full latency.
        sw_in = 4'h1;
        tick(6);
        check("stable_sw_early", 32'(sw_out), 32'h0);
        tick(1);
        check("stable_rise", 32'(rise), 32'h1);
        check("stable_sw", 32'(sw_out), 32'h1);
        tick(1);
        check("stable_rise_once", 32'(rise), 32'h0);
        sw_in = 4'h0;
        tick(7);
        check("ch0_fall", 32'(fall), 32'h1);
        tick(2);

        // Bounce train on channel 2, then hold high.
        acc = 0;
        for (int p = 0; p < 10; p++) begin
            sw_in = (p % 2 == 0) ? 4'h4 : 4'h0;
            for (int i = 0; i < 2; i++) begin
                tick(1);
                if (rise[2]) acc++;
            end
        end
        check("bounce_none", 32'(acc), 32'h0);
        sw_in = 4'h4;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (rise[2]) acc++;
        end
        check("bounce_early", 32'(acc), 32'h0);
        tick(1);
        check("bounce_rise", 32'(rise), 32'h4);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            if (rise[2]) acc++;
        end
        check("bounce_one_pulse", 32'(acc), 32'h0);
        sw_in = 4'h0;
        tick(9);
        check("bounce_low", 32'(sw_out), 32'h0);

        // Independent channels 0 and 2 together.
        acc = 0;
        sw_in = 4'b0101;
        tick(6);
        if (changed) acc++;
        tick(1);
        check("ind_rise", 32'(rise), 32'h5);
        check("ind_sw", 32'(sw_out), 32'h5);
        if (changed) acc++;
        tick(1);
        if (changed) acc++;
        sw_in = 4'b0000;
        tick(6);
        if (changed) acc++;
        tick(1);
        check("ind_fall", 32'(fall), 32'h5);
        if (changed) acc++;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            if (changed) acc++;
        end
        check("ind_changed_count", 32'(acc), 32'h2);

        // Bypass: single-cycle pulse on channel 3 passes through after 2 edges.
        bypass = 1'b1;
        tick(2);
        check("byp_idle", 32'({sw_out, rise, fall}), 32'h0);
        sw_in = 4'h8;
        tick(1);
        sw_in = 4'h0;
        tick(1);
        check("byp_sw_e1", 32'(sw_out), 32'h0);
        tick(1);
        check("byp_sw_e2", 32'(sw_out), 32'h8);
        check("byp_rise", 32'(rise), 32'h8);
        check("byp_changed", 32'(changed), 32'h1);
        tick(1);
        check("byp_sw_e3", 32'(sw_out), 32'h0);
        check("byp_fall", 32'(fall), 32'h8);
        check("byp_rise_off", 32'(rise), 32'h0);
        tick(1);
        check("byp_fall_off", 32'(fall), 32'h0);
        acc = 0;
        bypass = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (changed || (rise != 4'h0) || (fall != 4'h0)) acc++;
        end
        check("byp_exit_quiet", 32'(acc), 32'h0);

        // Reset in the middle of a confirm on channel 1.
        acc = 0;
        sw_in = 4'h2;
        tick(4);
        if (rise != 4'h0) acc++;
        rst_n = 1'b0;
        tick(1);
        if (rise != 4'h0) acc++;
        check("midrst_sw", 32'(sw_out), 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (rise != 4'h0) acc++;
        end
        check("midrst_no_early_rise", 32'(acc), 32'h0);
        tick(1);
        check("midrst_rise", 32'(rise), 32'h2);
        check("midrst_sw_hi", 32'(sw_out), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
